pts_tx_ctrl: RTL and testbench
==============================

PTS_TX_CTRL -- requirements
Module: pts_tx_ctrl

Interface
REQ-001 SR_SIZE_BITS, default 4: width of the word sent per transfer and number of shift pulses issued.
REQ-002 The block SHALL have a single clock domain; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock; all state updates occur on its rising edge.
REQ-004 n_rst  in  1  synchronous active-low reset, sampled on the rising clk edge.
REQ-005 tx_valid  in  1  requester offers a word.
REQ-006 tx_data  in  SR_SIZE_BITS  word to send, MSB first.
REQ-007 bit_period  in  8  clk cycles per serial bit; value 0 is treated as 1.
REQ-008 abort  in  1  cancels any transfer in progress.
REQ-009 tx_ready  out  1  controller can accept a word this cycle.
REQ-010 busy  out  1  transfer in progress (any state other than IDLE).
REQ-011 tx_done  out  1  one-cycle pulse on normal completion.
REQ-012 load_enable  out  1  drives the shift register's load_enable.
REQ-013 shift_enable  out  1  drives the shift register's shift_enable.
REQ-014 parallel_out  out  SR_SIZE_BITS  drives the shift register's parallel_in.

Function
REQ-015 States: IDLE, LOAD, SHIFT, DONE; outputs SHALL be decoded from registered state, counters and latched data only, with no combinational input-to-output path except tx_ready gating by n_rst.
REQ-016 IDLE: tx_ready=1, busy=0, load_enable=0, shift_enable=0, parallel_out=all ones.
REQ-017 Handshake: tx_valid=1 and tx_ready=1 at a rising edge SHALL latch tx_data and BP=max(bit_period,1), and move to LOAD.
REQ-018 tx_data and bit_period changes after the handshake SHALL NOT affect the transfer in progress.
REQ-019 LOAD lasts exactly 1 cycle: load_enable=1, parallel_out=latched word, tx_ready=0; next state SHIFT with bit timer=0 and bit count=0.
REQ-020 SHIFT: each bit SHALL be held for exactly BP cycles, with shift_enable=1 only in the last cycle of each bit (timer==BP-1); the timer SHALL then wrap to 0 and the bit count SHALL increment.
REQ-021 After the SR_SIZE_BITS-th shift pulse the state SHALL go to DONE; exactly SR_SIZE_BITS shift pulses are issued per transfer.
REQ-022 DONE lasts 1 cycle: tx_done=1, busy=1, tx_ready=0; next state IDLE.
REQ-023 Latency from the handshake edge to tx_done high SHALL be 1 + SR_SIZE_BITS*BP cycles; back-to-back transfers SHALL have at least one IDLE cycle between them.
REQ-024 parallel_out SHALL hold the latched word from LOAD through DONE; load_enable and shift_enable SHALL never both be 1 in the same cycle.
REQ-025 abort=1 at a rising edge in LOAD, SHIFT or DONE SHALL move to a 1-cycle ABORT action: load_enable=1 with parallel_out=all ones (restoring the idle line level), tx_done=0, then IDLE.
REQ-026 abort=1 in IDLE together with a valid handshake: abort SHALL win; no word is latched and the state stays IDLE.
REQ-027 BP=1: shift_enable SHALL be 1 in every SHIFT cycle (SR_SIZE_BITS consecutive cycles).
REQ-028 BP=255 SHALL hold each bit for 255 cycles; the timer SHALL NOT overflow.

Reset
REQ-029 At any rising edge with n_rst=0: state=IDLE, timer=0, bit count=0, latched word=all ones, BP latch=1.
REQ-030 While n_rst=0, tx_ready SHALL be 0; load_enable=0, shift_enable=0, tx_done=0, busy=0, and parallel_out=all ones.
REQ-031 A reset during LOAD, SHIFT or DONE SHALL abandon the transfer without a tx_done pulse and without a load or shift pulse.

Verification
REQ-032 Reset with tx_valid=1 and tx_data=0000 -> after the first edge, all outputs are at reset values, tx_ready=0; after n_rst is released, tx_ready=1.
REQ-033 tx_data=1010, bit_period=3 with the controller driving a 4-bit MSB-first PTS SR -> serial_out is 1,0,1,0 for 3 cycles each; tx_done fires 13 cycles after the handshake; serial_out then returns to 1.
REQ-034 bit_period=0 and bit_period=1 -> 4 consecutive shift_enable cycles; tx_done fires 5 cycles after the handshake.
REQ-035 abort asserted during the 2nd bit (bit_period=4) -> the next cycle has load_enable=1 with parallel_out=1111, there is no tx_done pulse, and tx_ready=1 one cycle later.
REQ-036 tx_valid held high with data 0011 then 1100 -> two transfers with one IDLE cycle between them; changing bit_period mid-transfer does not alter the current bit timing.
REQ-037 n_rst=0 during SHIFT -> no further shift pulses, busy=0, and tx_done is never asserted.

Source files
------------

// File: rtl/pts_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pts_tx_ctrl
//  Purpose  : Sequences load/shift pulses for a parallel-to-serial shift
//             register, sending one latched word MSB first.
//  Revision : 1.0
// ============================================================================
module pts_tx_ctrl #(
    parameter int SR_SIZE_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    tx_valid,
    input  logic [SR_SIZE_BITS-1:0] tx_data,
    input  logic [7:0]              bit_period,
    input  logic                    abort,
    output logic                    tx_ready,
    output logic                    busy,
    output logic                    tx_done,
    output logic                    load_enable,
    output logic                    shift_enable,
    output logic [SR_SIZE_BITS-1:0] parallel_out
);

    localparam int CNT_W = (SR_SIZE_BITS > 1) ? $clog2(SR_SIZE_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SR_SIZE_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t                  state;
    logic [7:0]              timer;
    logic [7:0]              bp;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SR_SIZE_BITS-1:0] word;
    logic                    bit_end;

    // bp is never 0, so bp-1 cannot underflow and timer stays below 255.
    assign bit_end = (timer == (bp - 8'd1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            timer   <= 8'd0;
            bit_cnt <= '0;
            word    <= '1;
            bp      <= 8'd1;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid && !abort) begin
                        word  <= tx_data;
                        bp    <= (bit_period == 8'd0) ? 8'd1 : bit_period;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= ABORT;
                    end else begin
                        timer   <= 8'd0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= ABORT;
                    end else if (bit_end) begin
                        timer   <= 8'd0;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= DONE;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE:    state <= abort ? ABORT : IDLE;
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Only tx_ready sees n_rst directly so it drops during reset immediately.
    assign tx_ready     = n_rst && (state == IDLE);
    assign busy         = (state != IDLE);
    assign tx_done      = (state == DONE);
    assign load_enable  = (state == LOAD) || (state == ABORT);
    assign shift_enable = (state == SHIFT) && bit_end;
    assign parallel_out = ((state == LOAD) || (state == SHIFT) || (state == DONE)) ? word : '1;

endmodule
`default_nettype wire

// File: tb/tb_pts_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pts_tx_ctrl
//  Purpose  : Self-checking bench for pts_tx_ctrl driving a modelled PTS SR.
//  Revision : 1.0
// ============================================================================
module tb_pts_tx_ctrl;

    localparam int SR = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          tx_valid = 1'b0;
    logic          abort = 1'b0;
    logic [SR-1:0] tx_data = '0;
    logic [7:0]    bit_period = 8'd0;
    logic          tx_ready, busy, tx_done, load_enable, shift_enable;
    logic [SR-1:0] parallel_out;

    int checks = 0;
    int errors = 0;

    // {tx_ready, busy, tx_done, load_enable, shift_enable, parallel_out}
    logic [SR+4:0] outs;
    assign outs = {tx_ready, busy, tx_done, load_enable, shift_enable, parallel_out};

    // Downstream MSB-first shift register, refilled with ones (idle line level)
    logic [SR-1:0] sr_q = '1;
    logic          serial_out;
    assign serial_out = sr_q[SR-1];
    always @(posedge clk) begin
        if (load_enable)       sr_q <= parallel_out;
        else if (shift_enable) sr_q <= {sr_q[SR-2:0], 1'b1};
    end

    pts_tx_ctrl #(.SR_SIZE_BITS(SR)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .bit_period   (bit_period),
        .abort        (abort),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .tx_done      (tx_done),
        .load_enable  (load_enable),
        .shift_enable (shift_enable),
        .parallel_out (parallel_out)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        n_rst = 1'b0; tx_valid = 1'b1; tx_data = '0; bit_period = 8'd3;
        @(posedge clk); @(negedge clk);
        checks++;
        if (outs !== {5'b00000, {SR{1'b1}}}) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", outs, {5'b00000, {SR{1'b1}}});
        end
        @(posedge clk); #1;
        n_rst = 1'b1; tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== {5'b10000, {SR{1'b1}}}) begin
            errors++; $display("FAIL reset_release: got %b want %b", outs, {5'b10000, {SR{1'b1}}});
        end
    endtask

    task automatic test_shift_timing();
        logic [SR-1:0] d;
        logic [7:0]    bp;
        logic [SR+4:0] exp_o;
        logic          exp_ser;
        int            bpe, total, pulses;
        for (int c = 0; c < 12; c++) begin
            d  = SR'($urandom);
            bp = 8'($urandom_range(1, 6));
            case (c)
                0:       begin d = 4'b1010; bp = 8'd3; end
                1:       bp = 8'd0;
                2:       bp = 8'd1;
                3:       bp = 8'd255;
                default: ;
            endcase
            bpe    = (bp == 8'd0) ? 1 : int'(bp);
            total  = 1 + SR * bpe;
            pulses = 0;
            @(posedge clk); #1;
            tx_valid = 1'b1; tx_data = d; bit_period = bp;
            @(posedge clk); #1;
            tx_valid = 1'b0;
            for (int j = 0; j <= total + 1; j++) begin
                if (j > 0) begin
                    @(posedge clk); #1;
                    tx_data = SR'($urandom); bit_period = 8'($urandom);
                end
                @(negedge clk);
                exp_o = {1'(j == total + 1), 1'(j <= total), 1'(j == total), 1'(j == 0),
                         1'(j >= 1 && j < total && (j % bpe) == 0),
                         (j <= total) ? d : {SR{1'b1}}};
                checks++;
                if (outs !== exp_o) begin
                    errors++;
                    $display("FAIL xfer case=%0d j=%0d: got %b want %b", c, j, outs, exp_o);
                end
                if (shift_enable) pulses++;
                if (j >= 1) begin
                    exp_ser = (j < total) ? d[SR-1-(j-1)/bpe] : 1'b1;
                    checks++;
                    if (serial_out !== exp_ser) begin
                        errors++;
                        $display("FAIL serial case=%0d j=%0d: got %b want %b", c, j, serial_out, exp_ser);
                    end
                end
            end
            checks++;
            if (pulses != SR) begin
                errors++; $display("FAIL shift_count case=%0d: got %0d want %0d", c, pulses, SR);
            end
        end
    endtask

    task automatic test_abort();
        logic [SR-1:0] d;
        int            jj;
        localparam int BPE = 4;
        localparam int TOTAL = 1 + SR * BPE;
        for (int c = 0; c < 6; c++) begin
            d  = SR'($urandom);
            jj = (c == 0) ? BPE + 1 : (c == 1) ? 0 : (c == 2) ? TOTAL : BPE + 1 + $urandom_range(0, 3);
            @(posedge clk); #1;
            tx_valid = 1'b1; tx_data = d; bit_period = 8'(BPE);
            @(posedge clk); #1;
            tx_valid = 1'b0; abort = (jj == 0);
            for (int j = 0; j <= jj; j++) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL abort_pre_busy case=%0d j=%0d: got %b want 1", c, j, busy);
                end
                if (j < jj) begin
                    @(posedge clk); #1;
                    abort = (j + 1 == jj);
                end
            end
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            checks++;
            if (outs !== {5'b01010, {SR{1'b1}}}) begin
                errors++;
                $display("FAIL abort_cycle case=%0d: got %b want %b", c, outs, {5'b01010, {SR{1'b1}}});
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if ({outs, serial_out} !== {5'b10000, {SR{1'b1}}, 1'b1}) begin
                errors++;
                $display("FAIL abort_idle case=%0d: got %b want %b", c, {outs, serial_out}, {5'b10000, {SR{1'b1}}, 1'b1});
            end
        end
        // Abort in IDLE must win over a simultaneous handshake
        @(posedge clk); #1;
        tx_valid = 1'b1; abort = 1'b1; tx_data = SR'($urandom); bit_period = 8'd2;
        @(posedge clk); #1;
        tx_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== {5'b10000, {SR{1'b1}}}) begin
            errors++; $display("FAIL abort_idle_wins: got %b want %b", outs, {5'b10000, {SR{1'b1}}});
        end
    endtask

    task automatic test_back_to_back();
        logic [SR-1:0] dat;
        logic [SR+4:0] exp_o;
        int            base, bpe, k, tot;
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = 4'b0011; bit_period = 8'd2;
        @(posedge clk); #1;
        for (int j = 0; j <= 33; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
                if (j == 2)  bit_period = 8'd5;
                if (j == 10) tx_data = 4'b1100;
                if (j == 11) tx_valid = 1'b0;
            end
            @(negedge clk);
            if (j <= 10) begin base = 0;  bpe = 2; dat = 4'b0011; end
            else         begin base = 11; bpe = 5; dat = 4'b1100; end
            k   = j - base;
            tot = 1 + SR * bpe;
            exp_o = {1'(k == tot + 1), 1'(k <= tot), 1'(k == tot), 1'(k == 0),
                     1'(k >= 1 && k < tot && (k % bpe) == 0),
                     (k <= tot) ? dat : {SR{1'b1}}};
            checks++;
            if (outs !== exp_o) begin
                errors++; $display("FAIL b2b j=%0d: got %b want %b", j, outs, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = SR'($urandom); bit_period = 8'd3;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 n_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (outs !== {5'b00000, {SR{1'b1}}}) begin
                errors++; $display("FAIL reset_mid k=%0d: got %b want %b", k, outs, {5'b00000, {SR{1'b1}}});
            end
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== {5'b10000, {SR{1'b1}}}) begin
                errors++; $display("FAIL reset_after k=%0d: got %b want %b", k, outs, {5'b10000, {SR{1'b1}}});
            end
            @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_shift_timing();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
